// File: rtl/plot_arbiter_pkg.sv
// rtl/plot_arbiter_pkg.sv - shared types and defaults for the plot arbiter.
package plot_arbiter_pkg;

  localparam int DEFAULT_SCREEN_W = 160;
  localparam int DEFAULT_SCREEN_H = 120;
  localparam int ENTRY_W          = 18;

  typedef enum logic [1:0] {
    ST_PASS  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } plot_entry_t;

endpackage

// File: rtl/plot_fifo.sv
// rtl/plot_fifo.sv - synchronous FIFO for one plot source; push while full is ignored.
module plot_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CNT_FULL);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_q];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/plot_arbiter.sv
// rtl/plot_arbiter.sv - two-source pixel arbiter with full-screen clear sweep for a VGA adapter.
// Define PLOT_ARBITER_CLIP_EN to discard popped pixels that fall outside the screen.
module plot_arbiter
  import plot_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = DEFAULT_SCREEN_W,
  parameter int SCREEN_H   = DEFAULT_SCREEN_H
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       clear_req,
  input  logic [2:0] clear_colour,
  input  logic       plot0,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [2:0] colour0,
  input  logic       plot1,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  input  logic [2:0] colour1,
  output logic       ready0,
  output logic       ready1,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       writeEn,
  output logic       busy,
  output logic       clear_done
);

  localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
  localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);
`ifdef PLOT_ARBITER_CLIP_EN
  localparam logic [8:0] X_LIM = 9'(SCREEN_W);
  localparam logic [7:0] Y_LIM = 8'(SCREEN_H);
`endif

  state_t      state_q, state_d;
  logic [7:0]  x_q, x_d, sx_q, sx_d;
  logic [6:0]  y_q, y_d, sy_q, sy_d;
  logic [2:0]  col_q, col_d, fill_q, fill_d;
  logic        we_q, we_d;
  logic        pop0, pop1, full0, full1, empty0, empty1, has_pop;
  plot_entry_t ent0, ent1, sel;

  plot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo0 (
    .clk_i(CLOCK_50), .rst_i(reset), .push_i(plot0), .data_i({x0, y0, colour0}),
    .pop_i(pop0), .data_o(ent0), .full_o(full0), .empty_o(empty0)
  );

  plot_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ENTRY_W)) u_fifo1 (
    .clk_i(CLOCK_50), .rst_i(reset), .push_i(plot1), .data_i({x1, y1, colour1}),
    .pop_i(pop1), .data_o(ent1), .full_o(full1), .empty_o(empty1)
  );

  assign ready0     = !full0;
  assign ready1     = !full1;
  assign x          = x_q;
  assign y          = y_q;
  assign colour     = col_q;
  assign writeEn    = we_q;
  assign busy       = (state_q == ST_CLEAR);
  assign clear_done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    col_d   = col_q;
    we_d    = 1'b0;
    sx_d    = sx_q;
    sy_d    = sy_q;
    fill_d  = fill_q;
    pop0    = 1'b0;
    pop1    = 1'b0;
    has_pop = 1'b0;
    sel     = ent0;
    case (state_q)
      ST_PASS: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          fill_d  = clear_colour;
          sx_d    = '0;
          sy_d    = '0;
          x_d     = '0;
          y_d     = '0;
          col_d   = clear_colour;
          we_d    = 1'b1;
        end else if (!empty1) begin
          pop1    = 1'b1;
          has_pop = 1'b1;
          sel     = ent1;
        end else if (!empty0) begin
          pop0    = 1'b1;
          has_pop = 1'b1;
          sel     = ent0;
        end
        if (has_pop) begin
`ifdef PLOT_ARBITER_CLIP_EN
          if (({1'b0, sel.x} < X_LIM) && ({1'b0, sel.y} < Y_LIM)) begin
            x_d   = sel.x;
            y_d   = sel.y;
            col_d = sel.colour;
            we_d  = 1'b1;
          end
`else
          x_d   = sel.x;
          y_d   = sel.y;
          col_d = sel.colour;
          we_d  = 1'b1;
`endif
        end
      end
      ST_CLEAR: begin
        // sx/sy hold the pixel currently on the output port.
        if (sx_q == X_LAST && sy_q == Y_LAST) begin
          state_d = ST_DONE;
          sx_d    = '0;
          sy_d    = '0;
        end else begin
          if (sx_q == X_LAST) begin
            sx_d = '0;
            sy_d = sy_q + 7'd1;
          end else begin
            sx_d = sx_q + 8'd1;
          end
          x_d   = sx_d;
          y_d   = sy_d;
          col_d = fill_q;
          we_d  = 1'b1;
        end
      end
      default: state_d = ST_PASS;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q <= ST_PASS;
      x_q     <= '0;
      y_q     <= '0;
      col_q   <= '0;
      we_q    <= 1'b0;
      sx_q    <= '0;
      sy_q    <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      col_q   <= col_d;
      we_q    <= we_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_plot_arbiter.sv
// tb/tb_plot_arbiter.sv - queue-based reference model plus directed and random checks for plot_arbiter.
module tb_plot_arbiter;
  localparam int DEPTH = 4;
  localparam int W = 160;
  localparam int H = 120;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clear_req, plot0, plot1;
  logic [2:0] clear_colour, c0, c1;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic       ready0, ready1, writeEn, busy, clear_done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;

  plot_arbiter #(.FIFO_DEPTH(DEPTH), .SCREEN_W(W), .SCREEN_H(H)) dut (
    .CLOCK_50(clk), .reset(rst), .clear_req(clear_req), .clear_colour(clear_colour),
    .plot0(plot0), .x0(x0), .y0(y0), .colour0(c0),
    .plot1(plot1), .x1(x1), .y1(y1), .colour1(c1),
    .ready0(ready0), .ready1(ready1), .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .busy(busy), .clear_done(clear_done)
  );

  int n_tests = 0;
  int n_fail = 0;
  int n_done = 0;

  // Reference model: per-source queues, mode 0=pass 1=clear 2=done, linear sweep index.
  pix_t q0[$];
  pix_t q1[$];
  int   mode = 0;
  int   idx = 0;
  logic [2:0] fill = '0;
  pix_t e_pix = '0;
  logic e_we = 1'b0;
  bit   m_f0, m_f1, m_got;
  pix_t m_p;

  bit   log_en = 1'b0;
  pix_t out_log[$];

  always @(posedge clk) begin
    if (rst) begin
      q0.delete(); q1.delete();
      mode = 0; idx = 0; fill = '0; e_pix = '0; e_we = 1'b0;
    end else begin
      m_f0 = (q0.size() >= DEPTH);
      m_f1 = (q1.size() >= DEPTH);
      e_we = 1'b0;
      m_got = 1'b0;
      m_p = '0;
      case (mode)
        0: begin
          if (clear_req) begin
            mode = 1; fill = clear_colour; idx = 0;
            e_pix = {8'd0, 7'd0, fill}; e_we = 1'b1;
          end else if (q1.size() > 0) begin
            m_p = q1.pop_front(); m_got = 1'b1;
          end else if (q0.size() > 0) begin
            m_p = q0.pop_front(); m_got = 1'b1;
          end
        end
        1: begin
          idx++;
          if (idx == W * H) mode = 2;
          else begin
            e_pix = {8'(idx % W), 7'(idx / W), fill};
            e_we = 1'b1;
          end
        end
        default: mode = 0;
      endcase
      if (m_got) begin
`ifdef PLOT_ARBITER_CLIP_EN
        if (int'(m_p.x) < W && int'(m_p.y) < H) begin
          e_pix = m_p; e_we = 1'b1;
        end
`else
        e_pix = m_p; e_we = 1'b1;
`endif
      end
      if (plot0 && !m_f0) q0.push_back({x0, y0, c0});
      if (plot1 && !m_f1) q1.push_back({x1, y1, c1});
    end
  end

  // Every-cycle comparison of the whole output port against the model.
  logic [7:0] ex;
  logic [6:0] ey;
  logic [2:0] ec;
  logic ewe, ebusy, edone, er0, er1;
  always @(negedge clk) begin
    if (rst) begin
      ex = '0; ey = '0; ec = '0; ewe = 0; ebusy = 0; edone = 0; er0 = 1; er1 = 1;
    end else begin
      ex = e_pix.x; ey = e_pix.y; ec = e_pix.c; ewe = e_we;
      ebusy = (mode == 1); edone = (mode == 2);
      er0 = (q0.size() < DEPTH); er1 = (q1.size() < DEPTH);
    end
    n_tests++;
    if ({x, y, colour, writeEn, busy, clear_done, ready0, ready1} !==
        {ex, ey, ec, ewe, ebusy, edone, er0, er1}) begin
      n_fail++;
      $display("FAIL cycle_cmp t=%0t got x=%0d y=%0d c=%0d we=%b busy=%b done=%b r0=%b r1=%b exp x=%0d y=%0d c=%0d we=%b busy=%b done=%b r0=%b r1=%b",
               $time, x, y, colour, writeEn, busy, clear_done, ready0, ready1,
               ex, ey, ec, ewe, ebusy, edone, er0, er1);
    end
    if (clear_done === 1'b1) n_done++;
    if (log_en && writeEn === 1'b1 && busy === 1'b0) out_log.push_back({x, y, colour});
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    plot0 = 0; plot1 = 0; clear_req = 0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (clear_done !== 1'b1 && k < 25000) begin
      @(negedge clk);
      k++;
    end
    chk("sweep_end_seen", 32'(clear_done), 1);
  endtask

  initial begin
    int cnt;
    int snap;
    int k;
    logic [7:0] lx;
    logic [6:0] ly;
    rst = 1; idle(); clear_colour = 0;
    x0 = 0; y0 = 0; c0 = 0; x1 = 0; y1 = 0; c1 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    chk("reset_we", 32'(writeEn), 0);
    chk("reset_xyc", 32'({x, y, colour}), 0);
    chk("reset_ready", 32'({ready0, ready1}), 3);
    chk("reset_busy_done", 32'({busy, clear_done}), 0);

    // Single push: pixel visible two cycles later, for one cycle only.
    tick(); plot0 = 1; x0 = 10; y0 = 20; c0 = 3'b110;
    tick(); idle();
    @(negedge clk); chk("lat_n1_we", 32'(writeEn), 0);
    @(negedge clk); chk("lat_n2_we", 32'(writeEn), 1);
    chk("lat_n2_pix", 32'({x, y, colour}), 32'({8'd10, 7'd20, 3'b110}));
    @(negedge clk); chk("lat_n3_we", 32'(writeEn), 0);

    // Same-cycle pushes: source1 wins.
    tick(); plot0 = 1; x0 = 1; y0 = 1; c0 = 3'b001; plot1 = 1; x1 = 2; y1 = 2; c1 = 3'b010;
    tick(); idle();
    @(negedge clk);
    @(negedge clk); chk("prio_first", 32'({writeEn, x, y, colour}), 32'({1'b1, 8'd2, 7'd2, 3'b010}));
    @(negedge clk); chk("prio_second", 32'({writeEn, x, y, colour}), 32'({1'b1, 8'd1, 7'd1, 3'b001}));

    // Fill FIFO0 while the sweep blocks pops.
    tick(); clear_req = 1; clear_colour = 3'b101;
    tick(); clear_req = 0;
    log_en = 1; out_log.delete();
    for (int i = 0; i < 6; i++) begin
      chk("ovf_ready0", 32'(ready0), (i < 4) ? 1 : 0);
      plot0 = 1; x0 = 8'(30 + i); y0 = 7'(40 + i); c0 = 3'(i);
      tick();
    end
    idle();
    chk("ovf_ready0_full", 32'(ready0), 0);
    wait_done();
    repeat (8) @(negedge clk);
    chk("ovf_count", 32'(out_log.size()), 4);
    for (int i = 0; i < 4 && i < out_log.size(); i++)
      chk("ovf_order", 32'(out_log[i]), 32'({8'(30 + i), 7'(40 + i), 3'(i)}));
    log_en = 0;

    // Full sweep with a second clear request mid-way.
    snap = n_done; cnt = 0; lx = '1; ly = '1;
    tick(); clear_colour = 3'b000; clear_req = 1;
    tick(); clear_req = 0;
    k = 0;
    while (clear_done !== 1'b1 && k < 25000) begin
      @(negedge clk);
      k++;
      if (writeEn === 1'b1 && busy === 1'b1) begin
        cnt++;
        if (cnt == 1) chk("sweep_first", 32'({x, y, colour}), 0);
        lx = x; ly = y;
      end
      clear_req = (cnt == 5000);
    end
    clear_req = 0;
    chk("sweep_count", cnt, W * H);
    chk("sweep_last", 32'({lx, ly}), 32'({8'd159, 7'd119}));
    repeat (3) @(negedge clk);
    chk("sweep_done_once", n_done - snap, 1);
    chk("sweep_idle_busy", 32'(busy), 0);

    // Reset in the middle of a sweep.
    tick(); clear_colour = 3'b111; clear_req = 1;
    tick(); clear_req = 0;
    k = 0;
    while (!(x === 8'd80 && y === 7'd60 && busy === 1'b1) && k < 25000) begin
      @(negedge clk);
      k++;
    end
    chk("abort_reached", 32'({x, y}), 32'({8'd80, 7'd60}));
    #1 rst = 1;
    snap = n_done;
    #1;
    chk("abort_outputs", 32'({x, y, colour, writeEn, busy, clear_done}), 0);
    chk("abort_ready", 32'({ready0, ready1}), 3);
    tick(); tick(); rst = 0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", n_done - snap, 0);

    // Off-screen pixel followed by the bottom-right corner.
    log_en = 1; out_log.delete();
    tick(); plot0 = 1; x0 = 160; y0 = 5; c0 = 3'b001;
    tick(); x0 = 159; y0 = 119; c0 = 3'b010;
    tick(); idle();
    repeat (5) @(negedge clk);
`ifdef PLOT_ARBITER_CLIP_EN
    chk("clip_count", 32'(out_log.size()), 1);
    if (out_log.size() > 0) chk("clip_pix", 32'(out_log[0]), 32'({8'd159, 7'd119, 3'b010}));
`else
    chk("clip_count", 32'(out_log.size()), 2);
    if (out_log.size() > 1) chk("clip_pix", 32'(out_log[1]), 32'({8'd159, 7'd119, 3'b010}));
`endif
    log_en = 0;

    // Random two-source traffic, model checked each cycle.
    for (int i = 0; i < 3000; i++) begin
      tick();
      plot0 = ($urandom_range(0, 99) < 45);
      plot1 = ($urandom_range(0, 99) < 30);
      x0 = 8'($urandom_range(0, 255)); y0 = 7'($urandom_range(0, 127)); c0 = 3'($urandom);
      x1 = 8'($urandom_range(0, 255)); y1 = 7'($urandom_range(0, 127)); c1 = 3'($urandom);
    end
    tick(); idle();
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/plot_arbiter.md
PLOT_ARBITER -- requirements
Module: plot_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, entries per source FIFO (power of two, 2..16).
REQ-002 Parameter: SCREEN_W, default 160, pixel columns; SCREEN_H, default 120, pixel rows.
REQ-003 CLOCK_50  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 clear_req  in  1  request full-screen fill; clear_colour  in  3  fill colour.
REQ-006 plot0  in  1  game-renderer push strobe; x0 in 8, y0 in 7, colour0 in 3  its pixel.
REQ-007 plot1  in  1  banner-renderer push strobe; x1 in 8, y1 in 7, colour1 in 3  its pixel.
REQ-008 ready0 / ready1  out  1  source FIFO not full.
REQ-009 x out 8, y out 7, colour out 3, writeEn out 1  registered plot port to the VGA adapter.
REQ-010 busy  out  1  clear sweep in progress; clear_done  out  1  one-cycle pulse at sweep end.

Function
REQ-011 Push to source FIFO k on a cycle with plotk=1 and readyk=1; plotk=1 with readyk=0 is dropped with no state change.
REQ-012 readyk = !fullk, derived from registered occupancy; simultaneous push and pop on a non-full, non-empty FIFO leaves occupancy unchanged.
REQ-013 States: PASS, CLEAR, DONE; reset enters PASS.
REQ-014 PASS: per cycle pop at most one entry, strict priority FIFO1 over FIFO0; popped entry registered onto x/y/colour with writeEn=1 next cycle; no pop -> writeEn=0 next cycle, x/y/colour hold.
REQ-015 Latency: push into empty FIFO, no contention, at cycle N -> writeEn=1 with that pixel in cycle N+2.
REQ-016 PASS with clear_req=1 in cycle N: no pop in N; latch clear_colour; enter CLEAR; pixel (0,0) driven with writeEn=1 in cycle N+1.
REQ-017 CLEAR: one pixel per cycle, raster order, x 0..SCREEN_W-1 inner, y 0..SCREEN_H-1 outer, colour = latched value; busy=1 throughout.
REQ-018 Last pixel (SCREEN_W-1, SCREEN_H-1) in cycle N+SCREEN_W*SCREEN_H; DONE in next cycle: clear_done=1, writeEn=0, busy=0; then PASS.
REQ-019 clear_req during CLEAR or DONE ignored (no restart, no queueing).
REQ-020 FIFOs accept pushes during CLEAR/DONE while not full, but are not popped until PASS.
REQ-021 FIFO entries emerge in push order per source; no entry duplicated or lost once accepted.

Reset
REQ-022 On reset: state PASS, both FIFOs empty, ready0=ready1=1, x=0, y=0, colour=0, writeEn=0, busy=0, clear_done=0, sweep counters 0.
REQ-023 Reset mid-sweep aborts the sweep immediately; no clear_done pulse issued.

Configuration
REQ-024 Macro PLOT_ARBITER_CLIP_EN defined: a popped entry with x>=SCREEN_W or y>=SCREEN_H is discarded (consumes the pop slot, writeEn=0 next cycle).
REQ-025 PLOT_ARBITER_CLIP_EN undefined: all popped entries emitted unchanged, no range check.

Structure
REQ-026 Shared package holds: state encoding, plot entry struct/width constant (18 bits x,y,colour), default SCREEN_W/SCREEN_H.
REQ-027 One sub-module plot_fifo (synchronous, FIFO_DEPTH entries, push/pop/full/empty), instantiated twice.

Verification
REQ-028 Reset, push (10,20,3'b110) on source0 at cycle 5 -> writeEn=1, x=10, y=20, colour=110 in cycle 7 only.
REQ-029 Same-cycle pushes (1,1,001) src0 and (2,2,010) src1 -> src1 pixel emitted first, src0 next cycle.
REQ-030 Hold plot0=1 with pops blocked by CLEAR, 6 distinct pixels -> first 4 accepted, ready0=0, last 2 dropped; after clear, exactly 4 emitted in order.
REQ-031 clear_req with clear_colour=3'b000 -> 19200 consecutive writeEn cycles covering (0,0)..(159,119), clear_done pulse once, second clear_req mid-sweep ignored.
REQ-032 Assert reset at sweep pixel (80,60) -> outputs reset values next cycle, no clear_done, ready0/ready1=1.
REQ-033 With PLOT_ARBITER_CLIP_EN, push (160,5) then (159,119) -> only (159,119) emitted; without macro both emitted.
